// File: rtl/mem_pkg.sv
// Shared definitions for the MIPS data memory: access-type codes, address limit
// and lane geometry used by both the store and load paths.
package mem_pkg;

  localparam logic [2:0] MEM_W  = 3'b000;
  localparam logic [2:0] MEM_HU = 3'b001;
  localparam logic [2:0] MEM_H  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b011;
  localparam logic [2:0] MEM_B  = 3'b100;

  localparam logic [31:0] ADDR_LIMIT = 32'h0000_3000;
  localparam int          LANES      = 4;

  typedef enum logic [1:0] {
    SZ_WORD,
    SZ_HALF,
    SZ_BYTE
  } size_e;

  // Codes 101-111 are not defined loads/stores and fall back to word access.
  function automatic size_e op_size(input logic [2:0] op);
    case (op)
      MEM_HU, MEM_H: return SZ_HALF;
      MEM_BU, MEM_B: return SZ_BYTE;
      default:       return SZ_WORD;
    endcase
  endfunction

  function automatic logic op_signed(input logic [2:0] op);
    return (op == MEM_H) || (op == MEM_B);
  endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte-lane steering for the data memory: one place decides which lanes a
// store touches and which lanes a load returns, so the two cannot disagree.
module dm_lane
  import mem_pkg::*;
(
  input  logic [1:0]       Offset,
  input  logic [2:0]       MemOp,
  input  logic [31:0]      WriteData,
  input  logic [31:0]      Word,
  output logic [LANES-1:0] ByteEn,
  output logic [31:0]      StoreWord,
  output logic [31:0]      LoadData
);

  logic [15:0] half;
  logic [7:0]  lane_byte;

  // Store data is replicated into every lane; ByteEn picks which copy lands.
  always_comb begin
    ByteEn    = '0;
    StoreWord = '0;
    LoadData  = '0;
    half      = '0;
    lane_byte = '0;
    case (op_size(MemOp))
      SZ_HALF: begin
        ByteEn    = Offset[1] ? 4'b1100 : 4'b0011;
        StoreWord = {2{WriteData[15:0]}};
        half      = Offset[1] ? Word[31:16] : Word[15:0];
        LoadData  = op_signed(MemOp) ? {{16{half[15]}}, half} : {16'h0000, half};
      end
      SZ_BYTE: begin
        ByteEn    = 4'b0001 << Offset;
        StoreWord = {4{WriteData[7:0]}};
        lane_byte = 8'(Word >> {Offset, 3'b000});
        LoadData  = op_signed(MemOp) ? {{24{lane_byte[7]}}, lane_byte}
                                     : {24'h000000, lane_byte};
      end
      default: begin
        ByteEn    = 4'b1111;
        StoreWord = WriteData;
        LoadData  = Word;
      end
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Data memory for the single-cycle MIPS CPU: synchronous byte-merged stores,
// combinational extended loads, and a per-store trace line.
module data_memory #(
  parameter int          WORDS      = 3072,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        WriteEn,
  input  logic [2:0]  MemOp,
  input  logic [31:0] PC,
  output logic [31:0] ReadData
);
  import mem_pkg::*;

  localparam int AW = $clog2(WORDS);

  logic [31:0]      mem [WORDS];
  logic [AW-1:0]    index;
  logic             in_range;
  logic [31:0]      cur_word;
  logic [31:0]      merged;
  logic [31:0]      store_word;
  logic [31:0]      load_data;
  logic [LANES-1:0] byte_en;

  assign index    = Address[AW+1:2];
  assign in_range = Address < ADDR_LIMIT;
  assign cur_word = in_range ? mem[index] : '0;

  dm_lane u_lane (
    .Offset    (Address[1:0]),
    .MemOp     (MemOp),
    .WriteData (WriteData),
    .Word      (cur_word),
    .ByteEn    (byte_en),
    .StoreWord (store_word),
    .LoadData  (load_data)
  );

  always_comb begin
    merged = cur_word;
    for (int i = 0; i < LANES; i++)
      if (byte_en[i]) merged[8*i +: 8] = store_word[8*i +: 8];
  end

  assign ReadData = in_range ? load_data : '0;

  // Reset wins over a store; out-of-range stores are silently dropped.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (WriteEn && in_range) begin
      mem[index] <= merged;
`ifndef SYNTHESIS
      $display("@%08h: *%08h <= %08h", PC, {Address[31:2], 2'b00}, merged);
`endif
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed cases plus random traffic
// compared against a byte-addressed reference memory.
module tb_data_memory;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        WriteEn;
  logic [2:0]  MemOp;
  logic [31:0] PC;
  logic [31:0] ReadData;

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0] mb [0:12287];

  data_memory dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Address   (Address),
    .WriteData (WriteData),
    .WriteEn   (WriteEn),
    .MemOp     (MemOp),
    .PC        (PC),
    .ReadData  (ReadData)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, observed, expected);
    end
  endtask

  function automatic void modelClear();
    for (int i = 0; i < 12288; i++) mb[i] = 8'h00;
  endfunction

  function automatic void modelStore(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
    int b;
    if (a >= 32'h3000) return;
    case (op)
      3'd1, 3'd2: begin
        b = int'(a & ~32'h1);
        mb[b] = d[7:0]; mb[b+1] = d[15:8];
      end
      3'd3, 3'd4: mb[int'(a)] = d[7:0];
      default: begin
        b = int'(a & ~32'h3);
        mb[b] = d[7:0]; mb[b+1] = d[15:8]; mb[b+2] = d[23:16]; mb[b+3] = d[31:24];
      end
    endcase
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] a, input logic [2:0] op);
    int b;
    logic [15:0] h;
    logic [7:0] y;
    if (a >= 32'h3000) return 32'h0;
    case (op)
      3'd1, 3'd2: begin
        b = int'(a & ~32'h1);
        h = {mb[b+1], mb[b]};
        return (op == 3'd2) ? 32'($signed(h)) : {16'h0, h};
      end
      3'd3, 3'd4: begin
        y = mb[int'(a)];
        return (op == 3'd4) ? 32'($signed(y)) : {24'h0, y};
      end
      default: begin
        b = int'(a & ~32'h3);
        return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
      end
    endcase
  endfunction

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
    @(negedge Clk);
    Address = a; WriteData = d; MemOp = op; WriteEn = 1'b1; Reset = 1'b0;
    @(posedge Clk);
    modelStore(a, d, op);
    #1;
    WriteEn = 1'b0;
    PC = PC + 32'd4;
  endtask

  task automatic checkLoad(input string tag, input logic [31:0] a, input logic [2:0] op);
    @(negedge Clk);
    Address = a; MemOp = op; WriteEn = 1'b0;
    #1;
    checkOutput(tag, ReadData, modelLoad(a, op));
  endtask

  task automatic checkConst(input string tag, input logic [31:0] a, input logic [2:0] op, input logic [31:0] exp);
    @(negedge Clk);
    Address = a; MemOp = op; WriteEn = 1'b0;
    #1;
    checkOutput(tag, ReadData, exp);
  endtask

  initial begin
    logic [31:0] a, d, old;
    logic [2:0] op;
    Reset = 1'b1; WriteEn = 1'b0; Address = '0; WriteData = '0; MemOp = 3'd0; PC = 32'h0000_3000;
    modelClear();
    @(posedge Clk); #1;
    Reset = 1'b0;

    checkConst("reset_lw", 32'h100, 3'd0, 32'h0);

    applyStimulus(32'h0, 32'h12345678, 3'd0);
    checkConst("sw_lw", 32'h0, 3'd0, 32'h12345678);
    checkConst("lw_unaligned", 32'h3, 3'd0, 32'h12345678);

    applyStimulus(32'h4, 32'h12345678, 3'd0);
    applyStimulus(32'h6, 32'hFFFF_FFAB, 3'd3);
    checkConst("sb_merge", 32'h4, 3'd0, 32'h12AB5678);
    checkConst("lb", 32'h6, 3'd4, 32'hFFFFFFAB);
    checkConst("lbu", 32'h6, 3'd3, 32'h000000AB);

    applyStimulus(32'h8, 32'h0, 3'd0);
    applyStimulus(32'hA, 32'h5555_8001, 3'd2);
    checkConst("sh_merge", 32'h8, 3'd0, 32'h80010000);
    checkConst("lh_hi", 32'hA, 3'd2, 32'hFFFF8001);
    checkConst("lhu_hi", 32'hA, 3'd1, 32'h00008001);
    checkConst("lh_lo", 32'h8, 3'd2, 32'h00000000);

    applyStimulus(32'h2FFC, 32'hDEADBEEF, 3'd0);
    applyStimulus(32'h3000, 32'h11111111, 3'd0);
    checkConst("lw_limit", 32'h3000, 3'd0, 32'h0);
    checkConst("lw_top", 32'h2FFC, 3'd0, 32'hDEADBEEF);
    checkConst("lw_far", 32'hFFFF_FFFC, 3'd0, 32'h0);

    applyStimulus(32'h10, 32'hCAFEF00D, 3'd0);
    @(negedge Clk);
    Address = 32'h10; WriteData = 32'h0BADC0DE; MemOp = 3'd0; WriteEn = 1'b1;
    #1;
    checkOutput("rdw_before", ReadData, 32'hCAFEF00D);
    @(posedge Clk);
    modelStore(32'h10, 32'h0BADC0DE, 3'd0);
    #1;
    WriteEn = 1'b0;
    checkOutput("rdw_after", ReadData, 32'h0BADC0DE);

    applyStimulus(32'h14, 32'h000000AA, 3'd3);
    applyStimulus(32'h15, 32'h000000BB, 3'd3);
    applyStimulus(32'h16, 32'h0000CCDD, 3'd1);
    checkConst("b2b_merge", 32'h14, 3'd0, 32'hCCDDBBAA);

    @(negedge Clk);
    Reset = 1'b1; WriteEn = 1'b1; Address = 32'h20; WriteData = 32'h99999999; MemOp = 3'd0;
    @(posedge Clk);
    modelClear();
    #1;
    Reset = 1'b0; WriteEn = 1'b0;
    checkConst("rst_prio", 32'h20, 3'd0, 32'h0);
    checkConst("rst_clears", 32'h2FFC, 3'd0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       a = $urandom_range(0, 32'h2FFF);
        1:       a = $urandom_range(32'h2FF0, 32'h3010);
        2:       a = $urandom();
        default: a = $urandom_range(0, 32'h3F);
      endcase
      op = 3'($urandom_range(0, 7));
      d = $urandom();
      if ($urandom_range(0, 1) == 0) applyStimulus(a, d, op);
      else checkLoad("rand_load", a, op);
    end

    for (int i = 0; i < 64; i += 4) begin
      old = modelLoad(32'(i), 3'd0);
      checkConst("rand_sweep", 32'(i), 3'd0, old);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Data memory for the single-cycle MIPS CPU. It is the load/store counterpart to the general register file: it holds program data at 0x0000_0000–0x0000_2FFF, directly below the initial stack pointer 0x2FFC. Stores (sw/sh/sb) are accepted synchronously, with byte-lane merge. Loads (lw/lh/lhu/lb/lbu) return combinational, lane-extracted, sign- or zero-extended data to the write-back mux.

## Interface
Parameters:
- WORDS, 3072, number of 32-bit words (12 KiB)
- ADDR_LIMIT, 32'h0000_3000, first byte address outside the memory

Ports:
- Clk  input  1  system clock; all state updates on posedge
- Reset  input  1  synchronous, active-high; clears every word on the next posedge
- Address  input  32  byte address from the ALU
- WriteData  input  32  store data, right-aligned (rt value)
- WriteEn  input  1  store strobe for the current instruction
- MemOp  input  3  access type; encoding in the package
- PC  input  32  PC of the current instruction, used for the trace print only
- ReadData  output  32  extended load result; combinational

## Operation
- Storage: WORDS x 32 array, indexed by Address[13:2].
- MemOp encoding:
  - 000 word
  - 001 half unsigned
  - 010 half signed
  - 011 byte unsigned
  - 100 byte signed
  - 101–111 behave as word
- Store lane selection:
  - Word writes all 4 lanes. Address[1:0] is ignored, so the access is force-aligned.
  - Half writes lanes {1,0} when Address[1]=0, else lanes {3,2}, using WriteData[15:0]. Address[0] is ignored.
  - Byte writes lane Address[1:0] with WriteData[7:0].
  - Unselected lanes keep their old contents.
- Load extraction uses the same lane rules.
  - Word: full word.
  - Half: selected halfword. Signed ops replicate bit 15; unsigned ops zero-fill.
  - Byte: selected byte, extended from bit 7 (signed) or zero-filled (unsigned).
  - Sign/zero extension applies only to loads. WriteData is never extended.
- Out of range (Address >= ADDR_LIMIT):
  - Store is dropped and nothing is printed.
  - ReadData = 0.
- Trace: every accepted store prints "@<PC 8 hex>: *<aligned word address 8 hex> <= <merged 32-bit word 8 hex>".
  - The printed value is the full post-merge word, not the raw WriteData.
  - The print is issued in the same posedge as the update.
- Reset: all words become 0. Reset has priority over WriteEn, so no store and no print occur during a reset cycle.

## Timing
- Store latency: 1 cycle. The array updates on the posedge where WriteEn=1 and Reset=0.
- Load latency: 0 cycles. ReadData depends only on Address, MemOp and the array, with no clock in the path.
- Read-during-write to the same word:
  - Before the edge, ReadData shows the old word.
  - After the edge, it shows the merged word.
  - There is no bypass.
- Back-to-back stores to the same word in consecutive cycles each merge against the result of the previous one.
- Reset mid-program: the array reads all-zero from the edge where Reset=1 onward. Stores resume on the first edge with Reset=0.
- Output reset value: ReadData = 0 after reset for any in-range address.
- WriteEn high with Address out of range: the array is unchanged for that cycle.

## Structure
- Shared package `mem_pkg`:
  - MemOp localparams: MEM_W, MEM_HU, MEM_H, MEM_BU, MEM_B.
  - ADDR_LIMIT.
  - The lane-enable width (4).
- Sub-module `dm_lane`, purely combinational, from Address[1:0] and MemOp:
  - 4-bit byte-enable mask and the shifted store word.
  - The load extractor/extender.
  - Shared by both paths so store and load lane rules cannot diverge.
- Top-level `data_memory`: the array, the reset loop, the merge, and the $display.

## Test plan
- Reset then word load: Reset=1 for one edge, then Address=0x100, MemOp=000 -> ReadData=0x00000000.
- Word store/load: sw 0x12345678 @0x0 -> trace "@00003000: *00000000 <= 12345678"; lw @0x3 -> 0x12345678 (forced alignment).
- Byte merge: preload 0x12345678 @0x4; sb 0xAB @0x6 -> word 0x12AB5678. Then:
  - lb @0x6 -> 0xFFFFFFAB
  - lbu @0x6 -> 0x000000AB
- Halfword merge: preload 0 @0x8; sh 0x8001 @0xA -> word 0x80010000. Then:
  - lh @0xA -> 0xFFFF8001
  - lhu @0xA -> 0x00008001
  - lh @0x8 -> 0x00000000
- Boundaries:
  - sw 0xDEADBEEF @0x2FFC -> stored; trace printed.
  - sw @0x3000 -> no trace; lw @0x3000 -> 0.
  - lw @0x2FFC -> 0xDEADBEEF.
- Priority and read-during-write:
  - Reset=1 and WriteEn=1 on the same edge -> no trace; the word stays 0.
  - sw to @0x10 while reading @0x10 -> old value before the edge, new value after it.
